// File: rtl/sr_flag_pkg.sv
// -----------------------------------------------------------------------------
// sr_flag_pkg
// Shared definitions for the SR flag arbiter:
//   OP_NOP / OP_CLR / OP_SET / OP_TGL : per-requester {s,r} op encodings
//   DEF_N_REQ, DEF_N_FLAG             : default requester count and flag count
// -----------------------------------------------------------------------------
package sr_flag_pkg;

    localparam logic [1:0] OP_NOP = 2'b00;
    localparam logic [1:0] OP_CLR = 2'b01;
    localparam logic [1:0] OP_SET = 2'b10;
    localparam logic [1:0] OP_TGL = 2'b11;

    localparam int DEF_N_REQ  = 4;
    localparam int DEF_N_FLAG = 8;

endpackage : sr_flag_pkg

// File: rtl/rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Round-robin arbiter with a registered search pointer.
// Ports:
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset (ptr -> 0, gnt forced to 0)
//   req  : [N] request vector
//   gnt  : [N] one-hot combinational grant, first req at or after ptr
// Handshake: a requester holds req high until it sees its gnt bit; the
// transaction completes on the rising edge where gnt is high, and ptr then
// moves to one past the winner. With no grant, ptr holds.
// -----------------------------------------------------------------------------
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req,
    output logic [N-1:0] gnt
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;

    logic [PW-1:0] ptr_q;
    logic [PW-1:0] ptr_d;
    logic          found;
    int            win;

    // Search starting at ptr and wrapping; gnt is gated by rst so an
    // in-flight grant disappears as soon as reset rises.
    always_comb begin
        gnt   = '0;
        found = 1'b0;
        win   = 0;
        ptr_d = ptr_q;
        for (int k = 0; k < N; k++) begin
            if (!rst && !found && req[(int'(ptr_q) + k) % N]) begin
                found = 1'b1;
                win   = (int'(ptr_q) + k) % N;
            end
        end
        if (found) begin
            gnt[win] = 1'b1;
            ptr_d    = PW'((win + 1) % N);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule : rr_arbiter

// File: rtl/sr_flag_arbiter.sv
// -----------------------------------------------------------------------------
// sr_flag_arbiter
// N_REQ requesters share a bank of N_FLAG set/reset flags. A round-robin
// arbiter picks one requester per cycle; its op is applied to the addressed
// flag on the granting edge.
// Ports:
//   clk       : rising-edge clock
//   rst       : asynchronous active-high reset
//   req_valid : [N_REQ] request pending
//   req_op    : [2*N_REQ] {s,r} per requester, slice i at [2i+1:2i]
//   req_idx   : [N_REQ*IDX_W] target flag index per requester
//   gnt       : [N_REQ] one-hot combinational grant
//   q         : [N_FLAG] registered flag bank
//   done      : one-cycle pulse, a transaction completed last edge
//   done_id   : requester served by the last done (holds otherwise)
//   err       : one-cycle pulse with done, illegal op or index
// Configuration macro: SR_FLAG_TOGGLE_EN -- when defined op 2'b11 toggles the
// flag; otherwise op 2'b11 is illegal (no flag change, err pulses).
// -----------------------------------------------------------------------------
module sr_flag_arbiter
    import sr_flag_pkg::*;
#(
    parameter int N_REQ  = DEF_N_REQ,
    parameter int N_FLAG = DEF_N_FLAG,
    parameter int IDX_W  = 3,
    localparam int ID_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_REQ-1:0]         req_valid,
    input  logic [2*N_REQ-1:0]       req_op,
    input  logic [N_REQ*IDX_W-1:0]   req_idx,
    output logic [N_REQ-1:0]         gnt,
    output logic [N_FLAG-1:0]        q,
    output logic                     done,
    output logic [ID_W-1:0]          done_id,
    output logic                     err
);

    logic [N_FLAG-1:0] q_q,       q_d;
    logic              done_q,    done_d;
    logic [ID_W-1:0]   done_id_q, done_id_d;
    logic              err_q,     err_d;

    logic              grant;
    logic [1:0]        sel_op;
    logic [IDX_W-1:0]  sel_idx;
    logic [ID_W-1:0]   sel_id;
    logic              idx_bad;
    logic              op_bad;

    rr_arbiter #(.N(N_REQ)) u_rr (
        .clk (clk),
        .rst (rst),
        .req (req_valid),
        .gnt (gnt)
    );

    // Mux the winning requester's op/idx out of the packed request buses.
    always_comb begin
        sel_op  = OP_NOP;
        sel_idx = '0;
        sel_id  = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (gnt[i]) begin
                sel_op  = req_op[2*i +: 2];
                sel_idx = req_idx[i*IDX_W +: IDX_W];
                sel_id  = ID_W'(i);
            end
        end
    end

    assign grant   = |gnt;
    assign idx_bad = (int'(sel_idx) >= N_FLAG);

`ifdef SR_FLAG_TOGGLE_EN
    assign op_bad = 1'b0;
`else
    assign op_bad = (sel_op == OP_TGL);
`endif

    // At most one flag bit changes: only the granted requester's index is
    // compared, and an illegal op or index leaves the bank untouched.
    always_comb begin
        q_d       = q_q;
        done_d    = grant;
        done_id_d = grant ? sel_id : done_id_q;
        err_d     = grant & (idx_bad | op_bad);
        if (grant && !idx_bad && !op_bad) begin
            for (int f = 0; f < N_FLAG; f++) begin
                if (int'(sel_idx) == f) begin
                    case (sel_op)
                        OP_SET:  q_d[f] = 1'b1;
                        OP_CLR:  q_d[f] = 1'b0;
                        OP_TGL:  q_d[f] = ~q_q[f];
                        default: q_d[f] = q_q[f];
                    endcase
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_q       <= '0;
            done_q    <= 1'b0;
            done_id_q <= '0;
            err_q     <= 1'b0;
        end else begin
            q_q       <= q_d;
            done_q    <= done_d;
            done_id_q <= done_id_d;
            err_q     <= err_d;
        end
    end

    assign q       = q_q;
    assign done    = done_q;
    assign done_id = done_id_q;
    assign err     = err_q;

endmodule : sr_flag_arbiter

// File: tb/tb_sr_flag_arbiter.sv
// -----------------------------------------------------------------------------
// tb_sr_flag_arbiter
// Directed vector table for the default 4x8 configuration plus hand-written
// sequences for reset, mid-cycle asynchronous reset and an out-of-range index
// on a 6-flag instance. Honours SR_FLAG_TOGGLE_EN for the op 2'b11 vector.
// -----------------------------------------------------------------------------
module tb_sr_flag_arbiter;

    logic        clk;
    logic        rst;
    logic [3:0]  req_valid;
    logic [7:0]  req_op;
    logic [11:0] req_idx;
    logic [3:0]  gnt;
    logic [7:0]  q;
    logic        done;
    logic [1:0]  done_id;
    logic        err;

    logic [3:0]  gnt6;
    logic [5:0]  q6;
    logic        done6;
    logic [1:0]  done_id6;
    logic        err6;

    int n_pass;
    int n_total;

    sr_flag_arbiter #(.N_REQ(4), .N_FLAG(8), .IDX_W(3)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_op    (req_op),
        .req_idx   (req_idx),
        .gnt       (gnt),
        .q         (q),
        .done      (done),
        .done_id   (done_id),
        .err       (err)
    );

    sr_flag_arbiter #(.N_REQ(4), .N_FLAG(6), .IDX_W(3)) u_dut6 (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_op    (req_op),
        .req_idx   (req_idx),
        .gnt       (gnt6),
        .q         (q6),
        .done      (done6),
        .done_id   (done_id6),
        .err       (err6)
    );

    // clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [3:0]  valid;
        logic [7:0]  op;
        logic [11:0] idx;
        logic [3:0]  exp_gnt;
        logic [7:0]  exp_q;
        logic        exp_done;
        logic [1:0]  exp_id;
        logic        exp_err;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    // Drive at posedge+1, check the combinational grant, then check the
    // registered results one edge later.
    task automatic apply(input int n, input vec_t v);
        req_valid = v.valid;
        req_op    = v.op;
        req_idx   = v.idx;
        #1;
        chk($sformatf("v%0d gnt", n), 32'(gnt), 32'(v.exp_gnt));
        @(posedge clk);
        #1;
        chk($sformatf("v%0d q", n),       32'(q),       32'(v.exp_q));
        chk($sformatf("v%0d done", n),    32'(done),    32'(v.exp_done));
        chk($sformatf("v%0d done_id", n), 32'(done_id), 32'(v.exp_id));
        chk($sformatf("v%0d err", n),     32'(err),     32'(v.exp_err));
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;

        //            valid    op {r3,r2,r1,r0}                 idx {r3,r2,r1,r0}                 gnt      q      dn  id     err
        // contention: all set idx i, ptr starts at 0
        vecs[0]  = '{4'b1111, {2'b10,2'b10,2'b10,2'b10}, {3'd3,3'd2,3'd1,3'd0}, 4'b0001, 8'h01, 1, 2'd0, 0};
        vecs[1]  = '{4'b1110, {2'b10,2'b10,2'b10,2'b10}, {3'd3,3'd2,3'd1,3'd0}, 4'b0010, 8'h03, 1, 2'd1, 0};
        vecs[2]  = '{4'b1100, {2'b10,2'b10,2'b10,2'b10}, {3'd3,3'd2,3'd1,3'd0}, 4'b0100, 8'h07, 1, 2'd2, 0};
        vecs[3]  = '{4'b1000, {2'b10,2'b10,2'b10,2'b10}, {3'd3,3'd2,3'd1,3'd0}, 4'b1000, 8'h0F, 1, 2'd3, 0};
        // idle: done drops, done_id holds, ptr stays 0
        vecs[4]  = '{4'b0000, 8'h00,                      12'h000,               4'b0000, 8'h0F, 0, 2'd3, 0};
        // single request: r2 set idx 5
        vecs[5]  = '{4'b0100, {2'b00,2'b10,2'b00,2'b00}, {3'd0,3'd5,3'd0,3'd0}, 4'b0100, 8'h2F, 1, 2'd2, 0};
        // ptr=3: r0 clear idx 0 found after wrap
        vecs[6]  = '{4'b0001, {2'b00,2'b00,2'b00,2'b01}, {3'd0,3'd0,3'd0,3'd0}, 4'b0001, 8'h2E, 1, 2'd0, 0};
        // ptr=1: r1 nop wins over r0, q unchanged but done fires
        vecs[7]  = '{4'b0011, {2'b00,2'b00,2'b00,2'b01}, {3'd0,3'd0,3'd4,3'd2}, 4'b0010, 8'h2E, 1, 2'd1, 0};
        // ptr=2: r0 (still waiting) clear idx 2
        vecs[8]  = '{4'b0001, {2'b00,2'b00,2'b00,2'b01}, {3'd0,3'd0,3'd4,3'd2}, 4'b0001, 8'h2A, 1, 2'd0, 0};
        // ptr=1: r1 clear idx 1
        vecs[9]  = '{4'b0010, {2'b00,2'b00,2'b01,2'b00}, {3'd0,3'd0,3'd1,3'd0}, 4'b0010, 8'h28, 1, 2'd1, 0};
        // ptr=2: r3 op 11 on idx 1 with q[1]=0
`ifdef SR_FLAG_TOGGLE_EN
        vecs[10] = '{4'b1000, {2'b11,2'b00,2'b00,2'b00}, {3'd1,3'd0,3'd0,3'd0}, 4'b1000, 8'h2A, 1, 2'd3, 0};
        vecs[11] = '{4'b0000, 8'h00,                      12'h000,               4'b0000, 8'h2A, 0, 2'd3, 0};
`else
        vecs[10] = '{4'b1000, {2'b11,2'b00,2'b00,2'b00}, {3'd1,3'd0,3'd0,3'd0}, 4'b1000, 8'h28, 1, 2'd3, 1};
        vecs[11] = '{4'b0000, 8'h00,                      12'h000,               4'b0000, 8'h28, 0, 2'd3, 0};
`endif

        // reset with all requesters valid
        rst       = 1'b1;
        req_valid = 4'b1111;
        req_op    = {2'b10,2'b10,2'b10,2'b10};
        req_idx   = {3'd3,3'd2,3'd1,3'd0};
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("rst gnt",     32'(gnt),     32'h0);
        chk("rst q",       32'(q),       32'h0);
        chk("rst done",    32'(done),    32'h0);
        chk("rst done_id", 32'(done_id), 32'h0);
        chk("rst err",     32'(err),     32'h0);
        rst = 1'b0;

        for (int i = 0; i < 12; i++) begin
            apply(i, vecs[i]);
        end

        // async reset mid-cycle while r1 holds the grant; ptr is 0 here
        req_valid = 4'b0010;
        req_op    = {2'b00,2'b00,2'b10,2'b00};
        req_idx   = {3'd0,3'd0,3'd7,3'd0};
        #1;
        chk("async pre gnt", 32'(gnt), 32'b0010);
        #2;
        rst = 1'b1;
        #1;
        chk("async gnt",  32'(gnt),  32'h0);
        chk("async q",    32'(q),    32'h0);
        chk("async done", 32'(done), 32'h0);
        @(posedge clk);
        #1;
        chk("async hold q",    32'(q),    32'h0);
        chk("async hold done", 32'(done), 32'h0);
        req_valid = 4'b0000;
        rst       = 1'b0;

        // out-of-range index on the 6-flag instance: r0 set idx 7
        req_valid = 4'b0001;
        req_op    = {2'b00,2'b00,2'b00,2'b10};
        req_idx   = {3'd0,3'd0,3'd0,3'd7};
        #1;
        chk("bad gnt6", 32'(gnt6), 32'b0001);
        @(posedge clk);
        #1;
        chk("bad q6",    32'(q6),    32'h0);
        chk("bad done6", 32'(done6), 32'h1);
        chk("bad err6",  32'(err6),  32'h1);
        chk("wide q",    32'(q),     32'h80);
        chk("wide err",  32'(err),   32'h0);
        // r0 set idx 5 is legal on 6 flags; ptr back at 1, r0 found after wrap
        req_idx = {3'd0,3'd0,3'd0,3'd5};
        @(posedge clk);
        #1;
        chk("good q6",   32'(q6),   32'h20);
        chk("good err6", 32'(err6), 32'h0);
        req_valid = 4'b0000;
        @(posedge clk);
        #1;
        chk("idle done6", 32'(done6), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_sr_flag_arbiter

// File: doc/sr_flag_arbiter.md
SR_FLAG_ARBITER -- requirements
Module: sr_flag_arbiter

Interface
REQ-001 The block SHALL have parameter N_REQ, default 4, meaning the number of requesters.
REQ-002 The block SHALL have parameter N_FLAG, default 8, meaning the number of shared SR flag bits.
REQ-003 The block SHALL have parameter IDX_W, default 3, meaning the flag index width (clog2(N_FLAG)).
REQ-004 The block SHALL have port clk, input, width 1: the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port rst, input, width 1: the asynchronous, active-high reset.
REQ-006 The block SHALL have port req_valid, input, width N_REQ: per-requester request pending.
REQ-007 The block SHALL have port req_op, input, width 2*N_REQ: per-requester {s,r} (slice i at [2i+1:2i]).
REQ-008 The block SHALL have port req_idx, input, width N_REQ*IDX_W: per-requester target flag index.
REQ-009 The block SHALL have port gnt, output, width N_REQ: one-hot combinational grant.
REQ-010 The block SHALL have port q, output, width N_FLAG: the registered flag bank.
REQ-011 The block SHALL have port done, output, width 1: registered one-cycle pulse, op completed.
REQ-012 The block SHALL have port done_id, output, width clog2(N_REQ): requester served by the last done.
REQ-013 The block SHALL have port err, output, width 1: registered one-cycle pulse, illegal op or index.

Function
REQ-014 gnt SHALL be zero when req_valid is zero; otherwise it SHALL be one-hot, selecting the first valid requester at or after ptr, modulo N_REQ.
REQ-015 A transaction SHALL complete on the rising edge where gnt[i]=1; the requester SHALL hold valid/op/idx stable until then.
REQ-016 On completion, ptr SHALL become (i+1) mod N_REQ; ptr SHALL be unchanged in cycles with no grant.
REQ-017 Op 2'b10 (set) SHALL make q[idx]=1 and op 2'b01 (clear) SHALL make q[idx]=0, visible the cycle after grant.
REQ-018 Op 2'b00 SHALL leave q unchanged, and the transaction SHALL still complete with done.
REQ-019 On any completion, done SHALL be 1 and done_id SHALL be i in the next cycle; otherwise done SHALL be 0 and done_id SHALL hold.
REQ-020 If idx >= N_FLAG, q SHALL be unchanged and err SHALL pulse alongside done.
REQ-021 Only one flag bit SHALL change per cycle; with all N_REQ valid, each requester SHALL be served exactly once per N_REQ cycles.

Reset
REQ-022 While rst=1, q, ptr, done, done_id and err SHALL all be 0, and gnt SHALL be 0 regardless of req_valid.
REQ-023 A reset asserted mid-cycle SHALL abandon any in-flight grant, leave no flag updated, and suppress done.

Configuration
REQ-024 With macro SR_FLAG_TOGGLE_EN defined, op 2'b11 SHALL toggle q[idx] and SHALL NOT raise err.
REQ-025 Without SR_FLAG_TOGGLE_EN, op 2'b11 SHALL leave q unchanged and SHALL pulse err alongside done.

Structure
REQ-026 The shared package sr_flag_pkg SHALL hold the op encoding constants (OP_NOP, OP_CLR, OP_SET, OP_TGL) and the default N_REQ and N_FLAG.
REQ-027 Round-robin selection and ptr SHALL live in a sub-module rr_arbiter (parameter N, ports clk, rst, req, gnt); flag update logic SHALL be in the top level.

Verification
REQ-028 Reset: rst pulse, all req_valid=1 -> q=8'h00, gnt=0 during reset; first grant after reset is gnt=4'b0001.
REQ-029 Single request: requester 2 set, idx 5 -> gnt=4'b0100 for one cycle; next cycle q=8'h20, done=1, done_id=2.
REQ-030 Contention: all four valid, set idx 0..3 respectively -> grants 0001,0010,0100,1000 in consecutive cycles; then q=8'h0F.
REQ-031 Illegal op: op 2'b11 on idx 1 with q[1]=0 -> without macro, q[1]=0 and err=1; with SR_FLAG_TOGGLE_EN, q[1]=1 and err=0.
REQ-032 Bad index (N_FLAG=6, IDX_W=3): set idx 7 -> q unchanged, done=1, err=1.
REQ-033 Async reset mid-stream: rst rises between edges while gnt=4'b0010 -> q=0, done=0 immediately, without waiting for clk.
